iob_fifo_asym_w_big_ctrl: RTL and testbench

IOB_FIFO_ASYM_W_BIG_CTRL -- requirements
Module: iob_fifo_asym_w_big_ctrl

---
 rtl/iob_fifo_asym_w_big_ctrl.sv | 88 ++++++++
 tb/tb_iob_fifo_asym_w_big_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_asym_w_big_ctrl.sv
// iob_fifo_asym_w_big_ctrl: control logic for a FIFO that stores W_DATA_W-bit words and returns them as R_DATA_W-bit slices.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   clr                  synchronous clear of pointers, level and sticky flags
//   push, push_data      write one wide word; full means fewer than RATIO free narrow slots
//   pop, pop_data        read one narrow word; pop_data is valid when pop_valid is high
//   empty, level         narrow-word occupancy
//   overflow, underflow  sticky error flags
//   mem_w_*              wide write port of the external memory
//   mem_r_*              narrow read port of the external memory (1-cycle read latency)
module iob_fifo_asym_w_big_ctrl #(
  parameter  int W_DATA_W = 16,
  parameter  int R_DATA_W = 8,
  parameter  int W_ADDR_W = 6,
  localparam int RATIO    = W_DATA_W / R_DATA_W,
  localparam int LOG2R    = $clog2(RATIO),
  localparam int R_ADDR_W = W_ADDR_W + LOG2R,
  localparam int DEPTH_R  = 2 ** R_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                push,
  input  logic [W_DATA_W-1:0] push_data,
  output logic                full,
  input  logic                pop,
  output logic [R_DATA_W-1:0] pop_data,
  output logic                pop_valid,
  output logic                empty,
  output logic [R_ADDR_W:0]   level,
  output logic                overflow,
  output logic                underflow,
  output logic                mem_w_en,
  output logic [W_ADDR_W-1:0] mem_w_addr,
  output logic [W_DATA_W-1:0] mem_w_data,
  output logic                mem_r_en,
  output logic [R_ADDR_W-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0] mem_r_data
);
  localparam logic [R_ADDR_W:0] FULL_TH = (R_ADDR_W + 1)'(DEPTH_R - RATIO);
  logic [W_ADDR_W:0] wptr_q, wptr_d;
  logic [R_ADDR_W:0] rptr_q, rptr_d, level_q, level_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok;
  assign full      = level_q > FULL_TH;
  assign empty     = level_q == '0;
  assign level     = level_q;
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign pop_data  = mem_r_data;
  always_comb begin
    // rst_n gating keeps the memory strobes quiet while reset is held
    push_ok     = rst_n && push && !full && !clr;
    pop_ok      = rst_n && pop && !empty && !clr;
    wptr_d      = clr ? '0 : wptr_q + (W_ADDR_W + 1)'(push_ok);
    rptr_d      = clr ? '0 : rptr_q + (R_ADDR_W + 1)'(pop_ok);
    // write pointer scaled to narrow units; modular subtraction absorbs wrap
    level_d     = ((R_ADDR_W + 1)'(wptr_d) << LOG2R) - rptr_d;
    pop_valid_d = pop_ok;
    overflow_d  = !clr && (overflow_q || (push && full));
    underflow_d = !clr && (underflow_q || (pop && empty));
    mem_w_en    = push_ok;
    mem_w_addr  = wptr_q[W_ADDR_W-1:0];
    mem_w_data  = push_data;
    mem_r_en    = pop_ok;
    mem_r_addr  = rptr_q[R_ADDR_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_iob_fifo_asym_w_big_ctrl.sv
// tb_iob_fifo_asym_w_big_ctrl: directed self-checking bench for the asymmetric FIFO controller with a behavioural memory.
module tb_iob_fifo_asym_w_big_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, clr, push, pop;
  logic [15:0] push_data;
  logic        full, pop_valid, empty, overflow, underflow;
  logic [7:0]  pop_data;
  logic [7:0]  level;
  logic        mem_w_en, mem_r_en;
  logic [5:0]  mem_w_addr;
  logic [15:0] mem_w_data;
  logic [6:0]  mem_r_addr;
  logic [7:0]  mem_r_data;
  logic [7:0]  mem [128];
  int          tests = 0;
  int          fails = 0;

  iob_fifo_asym_w_big_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .push_data(push_data),
    .full(full), .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
    .empty(empty), .level(level), .overflow(overflow), .underflow(underflow),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  // wide-write / narrow-read memory, low slice at the even narrow address
  always @(posedge clk) begin
    if (mem_w_en) begin
      mem[{mem_w_addr, 1'b0}] <= mem_w_data[7:0];
      mem[{mem_w_addr, 1'b1}] <= mem_w_data[15:8];
    end
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (mem_w_en !== 1'b0) begin fails++; $display("FAIL reset_w_en got=%b exp=0", mem_w_en); end
    tests++; if (mem_r_en !== 1'b0) begin fails++; $display("FAIL reset_r_en got=%b exp=0", mem_r_en); end
    tests++; if (level !== 8'd0) begin fails++; $display("FAIL reset_level got=%0d exp=0", level); end
    tests++; if ({empty, full, pop_valid, overflow, underflow} !== 5'b10000) begin fails++; $display("FAIL reset_flags got=%b exp=10000", {empty, full, pop_valid, overflow, underflow}); end
    push = 1'b0; pop = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    @(negedge clk);
    push = 1'b1; push_data = 16'hBBAA;
    #1;
    tests++; if ({mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 6'd0, 16'hBBAA}) begin fails++; $display("FAIL basic_wr got=%b/%0d/%h exp=1/0/bbaa", mem_w_en, mem_w_addr, mem_w_data); end
    @(negedge clk);
    push = 1'b0;
    tests++; if ({empty, level} !== {1'b0, 8'd2}) begin fails++; $display("FAIL basic_level got=%b/%0d exp=0/2", empty, level); end
    pop = 1'b1;
    #1;
    tests++; if ({mem_r_en, mem_r_addr} !== {1'b1, 7'd0}) begin fails++; $display("FAIL basic_rd0 got=%b/%0d exp=1/0", mem_r_en, mem_r_addr); end
    @(negedge clk);
    tests++; if ({pop_valid, pop_data} !== {1'b1, 8'hAA}) begin fails++; $display("FAIL basic_pop0 got=%b/%h exp=1/aa", pop_valid, pop_data); end
    #1;
    tests++; if ({mem_r_en, mem_r_addr} !== {1'b1, 7'd1}) begin fails++; $display("FAIL basic_rd1 got=%b/%0d exp=1/1", mem_r_en, mem_r_addr); end
    @(negedge clk);
    pop = 1'b0;
    tests++; if ({pop_valid, pop_data, empty} !== {1'b1, 8'hBB, 1'b1}) begin fails++; $display("FAIL basic_pop1 got=%b/%h/%b exp=1/bb/1", pop_valid, pop_data, empty); end
    @(negedge clk);
    tests++; if (pop_valid !== 1'b0) begin fails++; $display("FAIL basic_idle got=%b exp=0", pop_valid); end
  endtask

  task automatic test_underflow;
    @(negedge clk);
    pop = 1'b1;
    #1;
    tests++; if (mem_r_en !== 1'b0) begin fails++; $display("FAIL unf_r_en got=%b exp=0", mem_r_en); end
    @(negedge clk);
    tests++; if ({pop_valid, underflow} !== 2'b01) begin fails++; $display("FAIL unf_flag got=%b exp=01", {pop_valid, underflow}); end
    push = 1'b1; push_data = 16'h0201;
    #1;
    tests++; if ({mem_w_en, mem_r_en} !== 2'b10) begin fails++; $display("FAIL unf_pushpop got=%b exp=10", {mem_w_en, mem_r_en}); end
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    tests++; if ({pop_valid, level} !== {1'b0, 8'd2}) begin fails++; $display("FAIL unf_after got=%b/%0d exp=0/2", pop_valid, level); end
    clr = 1'b1; push = 1'b1; pop = 1'b1;
    #1;
    tests++; if ({mem_w_en, mem_r_en} !== 2'b00) begin fails++; $display("FAIL clr_strobes got=%b exp=00", {mem_w_en, mem_r_en}); end
    @(negedge clk);
    clr = 1'b0; push = 1'b0; pop = 1'b0;
    tests++; if ({underflow, empty, level} !== {2'b01, 8'd0}) begin fails++; $display("FAIL clr_state got=%b/%b/%0d exp=0/1/0", underflow, empty, level); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 63) begin
        tests++; if ({full, level} !== {1'b0, 8'd126}) begin fails++; $display("FAIL full_edge got=%b/%0d exp=0/126", full, level); end
      end
      push = 1'b1; push_data = {8'(2 * i + 1), 8'(2 * i)};
    end
    @(negedge clk);
    tests++; if ({full, level} !== {1'b1, 8'd128}) begin fails++; $display("FAIL full_set got=%b/%0d exp=1/128", full, level); end
    push_data = 16'hFFFF;
    #1;
    tests++; if (mem_w_en !== 1'b0) begin fails++; $display("FAIL full_w_en got=%b exp=0", mem_w_en); end
    @(negedge clk);
    tests++; if ({overflow, level} !== {1'b1, 8'd128}) begin fails++; $display("FAIL full_ovf got=%b/%0d exp=1/128", overflow, level); end
    pop = 1'b1;
    #1;
    tests++; if ({mem_w_en, mem_r_en} !== 2'b01) begin fails++; $display("FAIL full_pushpop got=%b exp=01", {mem_w_en, mem_r_en}); end
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    tests++; if ({pop_valid, pop_data, level} !== {1'b1, 8'h00, 8'd127}) begin fails++; $display("FAIL full_pop got=%b/%h/%0d exp=1/00/127", pop_valid, pop_data, level); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests++; if ({overflow, full, level} !== {2'b00, 8'd0}) begin fails++; $display("FAIL full_clr got=%b/%b/%0d exp=0/0/0", overflow, full, level); end
  endtask

  task automatic test_simul;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      push = 1'b1; push_data = {8'(2 * i + 1), 8'(2 * i)};
    end
    @(negedge clk);
    tests++; if (level !== 8'd10) begin fails++; $display("FAIL simul_pre got=%0d exp=10", level); end
    pop = 1'b1; push_data = 16'h5A5A;
    #1;
    tests++; if ({mem_w_en, mem_r_en} !== 2'b11) begin fails++; $display("FAIL simul_strobes got=%b exp=11", {mem_w_en, mem_r_en}); end
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    tests++; if ({pop_valid, pop_data, level} !== {1'b1, 8'h00, 8'd11}) begin fails++; $display("FAIL simul_post got=%b/%h/%0d exp=1/00/11", pop_valid, pop_data, level); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_fill_drain;
    int base = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        push = 1'b1; push_data = {8'(base + 2 * i + 1), 8'(base + 2 * i)};
      end
      @(negedge clk);
      push = 1'b0;
      tests++; if ({full, level} !== {1'b1, 8'd128}) begin fails++; $display("FAIL fd_full round=%0d got=%b/%0d exp=1/128", r, full, level); end
      for (int i = 0; i <= 128; i++) begin
        if (i > 0) begin
          tests++; if ({pop_valid, pop_data} !== {1'b1, 8'(base + i - 1)}) begin fails++; $display("FAIL fd_data idx=%0d got=%b/%h exp=1/%h", base + i - 1, pop_valid, pop_data, 8'(base + i - 1)); end
        end
        pop = (i < 128);
        @(negedge clk);
      end
      tests++; if ({empty, pop_valid} !== 2'b10) begin fails++; $display("FAIL fd_empty round=%0d got=%b exp=10", r, {empty, pop_valid}); end
      base += 128;
    end
  endtask

  task automatic test_reset_inflight;
    @(negedge clk);
    push = 1'b1; push_data = 16'hD1C0;
    @(negedge clk);
    push = 1'b0; pop = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0; pop = 1'b0;
    #1;
    tests++; if ({pop_valid, empty, full, overflow, underflow, level} !== {5'b01000, 8'd0}) begin fails++; $display("FAIL rst_mid got=%b/%0d exp=01000/0", {pop_valid, empty, full, overflow, underflow}, level); end
    tests++; if ({mem_w_en, mem_r_en} !== 2'b00) begin fails++; $display("FAIL rst_mid_strobes got=%b exp=00", {mem_w_en, mem_r_en}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if ({pop_valid, level} !== {1'b0, 8'd0}) begin fails++; $display("FAIL rst_release cyc=%0d got=%b/%0d exp=0/0", i, pop_valid, level); end
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; push = 1'b1; pop = 1'b1; push_data = 16'h1234;
    test_reset;
    test_basic;
    test_underflow;
    test_full;
    test_simul;
    test_fill_drain;
    test_reset_inflight;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
